// File: rtl/sr_trace_tx_pkg.sv
// Shared types and constants for the retirement-trace UART transmitter.
// A frame is one sync byte followed by the big-endian pc and instr words.
package sr_trace_tx_pkg;

    localparam logic [7:0] SR_TRACE_SYNC  = 8'hA5;
    localparam int         SR_TRACE_BYTES = 9;

    typedef enum logic [1:0] {
        TRS_IDLE  = 2'd0,
        TRS_START = 2'd1,
        TRS_DATA  = 2'd2,
        TRS_STOP  = 2'd3
    } trs_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_rec_t;

    // The bit timer needs at least one bit, even when CLK_DIV is 1.
    function automatic int timer_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/sr_trace_tx_if.sv
// Trace capture inputs and UART/status outputs of sr_trace_tx.
// The CPU side is the master; the transmitter is the slave.
interface sr_trace_tx_if;

    logic        trEn;
    logic        trValid;
    logic [31:0] trPc;
    logic [31:0] trInstr;
    logic        txd;
    logic        busy;
    logic        overflow;
    logic [7:0]  dropCnt;

    modport master (
        output trEn, trValid, trPc, trInstr,
        input  txd, busy, overflow, dropCnt
    );

    modport slave (
        input  trEn, trValid, trPc, trInstr,
        output txd, busy, overflow, dropCnt
    );

endinterface

// File: rtl/sr_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is valid whenever !empty.
// A push while full is accepted only when a pop happens on the same edge.
module sr_trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sr_trace_tx.sv
// Captures {pc, instr} of retired instructions and sends each as a 9-byte
// UART 8N1 frame: sync, pc, instr (big-endian), LSB first within each byte.
module sr_trace_tx
    import sr_trace_tx_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = SR_TRACE_SYNC
) (
    input  logic         clk,
    input  logic         rst,
    sr_trace_tx_if.slave tr
);

    localparam int TW = timer_width(CLK_DIV);

    trs_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic [71:0]   shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    trace_rec_t    wr_rec;
    trace_rec_t    rd_rec;
    logic          rec_valid;
    logic          rec_drop;
    logic          bit_end;
    logic [7:0]    cur_byte;

    assign wr_rec = '{pc: tr.trPc, instr: tr.trInstr};

    sr_trace_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_rec),
        .rdata (rd_rec),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A full FIFO still accepts a record when the serialiser frees a slot on the same edge.
    assign rec_valid  = tr.trEn && tr.trValid;
    assign fifo_push  = rec_valid && (!fifo_full || fifo_pop);
    assign rec_drop   = rec_valid && !fifo_push;
    assign overflow_d = overflow_q || rec_drop;
    assign drop_cnt_d = (rec_drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

    assign bit_end  = (timer_q == TW'(CLK_DIV - 1));
    assign cur_byte = shreg_q[71:64];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        timer_d    = bit_end ? '0 : timer_q + TW'(1);
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        txd_d      = txd_q;
        fifo_pop   = 1'b0;

        case (state_q)
            TRS_IDLE: begin
                timer_d = '0;
                txd_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_d    = {SYNC_BYTE, rd_rec};
                    byte_idx_d = '0;
                    state_d    = TRS_START;
                    txd_d      = 1'b0;
                end
            end
            TRS_START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = TRS_DATA;
                    txd_d     = cur_byte[0];
                end
            end
            TRS_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = TRS_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end
            TRS_STOP: begin
                if (bit_end) begin
                    if (byte_idx_q < 4'(SR_TRACE_BYTES - 1)) begin
                        byte_idx_d = byte_idx_q + 4'd1;
                        shreg_d    = {shreg_q[63:0], 8'h00};
                        state_d    = TRS_START;
                        txd_d      = 1'b0;
                    end else begin
                        state_d = TRS_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: state_d = TRS_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TRS_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tr.txd      = txd_q;
    assign tr.busy     = !fifo_empty || (state_q != TRS_IDLE);
    assign tr.overflow = overflow_q;
    assign tr.dropCnt  = drop_cnt_q;

endmodule

// File: tb/tb_sr_trace_tx.sv
// Bench for sr_trace_tx: a queue/timeline model predicts txd, busy, overflow and
// dropCnt every cycle; directed scenarios add hand-computed expectations.
module tb_sr_trace_tx;

    localparam int CD    = 4;
    localparam int DEPTH = 2;
    localparam int FRAME = 90 * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_trace_tx_if tb_if ();

    sr_trace_tx #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tr  (tb_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending records plus the position inside the frame on the wire.
    logic [63:0] m_q [$];
    int          m_pos  = -1;
    logic [71:0] m_frame = '0;
    logic        m_ovf  = 1'b0;
    int          m_drop = 0;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_pos  = -1;
            m_ovf  = 1'b0;
            m_drop = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            if (m_pos < 0) begin
                if (m_q.size() > 0) begin
                    m_frame = {8'hA5, m_q.pop_front()};
                    m_pos   = 0;
                end
            end else if (m_pos == FRAME - 1) begin
                m_pos = -1;
            end else begin
                m_pos++;
            end
            if (tb_if.trEn && tb_if.trValid) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({tb_if.trPc, tb_if.trInstr});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    end

    function automatic logic exp_txd_f(input int pos, input logic [71:0] fr);
        int         bit_no;
        int         byte_no;
        int         slot;
        logic [7:0] val;
        if (pos < 0) return 1'b1;
        bit_no  = pos / CD;
        byte_no = bit_no / 10;
        slot    = bit_no % 10;
        val     = fr[71 - 8*byte_no -: 8];
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return val[slot - 1];
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            check("txd",      tb_if.txd,      exp_txd_f(m_pos, m_frame));
            check("busy",     tb_if.busy,     (m_q.size() > 0) || (m_pos >= 0));
            check("overflow", tb_if.overflow, m_ovf);
            check("dropCnt",  tb_if.dropCnt,  m_drop);
        end
    end

    logic       cap_samples [FRAME];
    logic [7:0] cap_bytes   [9];

    task automatic strobe(input logic [31:0] pc, input logic [31:0] instr);
        tb_if.trValid = 1'b1;
        tb_if.trPc    = pc;
        tb_if.trInstr = instr;
        @(negedge clk);
        tb_if.trValid = 1'b0;
    endtask

    // Call at the negedge right after the push edge; the frame starts on the next edge.
    task automatic capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            cap_samples[i] = tb_if.txd;
        end
        check("start_bit_latency", cap_samples[0], 1'b0);
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 8; j++)
                cap_bytes[k][j] = cap_samples[(10*k + 1 + j)*CD + CD/2];
        end
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (tb_if.busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", tb_if.busy, 1'b0);
    endtask

    initial begin
        logic [7:0]  exp_bytes [9];
        logic [71:0] fr;
        int          n;
        int          thr;

        tb_if.trEn    = 1'b1;
        tb_if.trValid = 1'b0;
        tb_if.trPc    = '0;
        tb_if.trInstr = '0;

        // Reset held 10 cycles with trValid toggling.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tb_if.trValid = ~tb_if.trValid;
            tb_if.trPc    = 32'(i * 4);
        end
        @(negedge clk);
        check("reset_txd", tb_if.txd, 1'b1);
        check("reset_busy", tb_if.busy, 1'b0);
        check("reset_dropCnt", tb_if.dropCnt, 8'd0);
        tb_if.trValid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Single record, fixed frame content and timing.
        strobe(32'h0000_0010, 32'h0050_0513);
        check("txd_idle_on_push_edge", tb_if.txd, 1'b1);
        check("busy_after_push", tb_if.busy, 1'b1);
        capture_frame();
        exp_bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h50, 8'h05, 8'h13};
        for (int k = 0; k < 9; k++) check($sformatf("frame1_byte%0d", k), cap_bytes[k], exp_bytes[k]);
        check("busy_at_360", tb_if.busy, 1'b1);
        @(negedge clk);
        check("busy_fell_at_361", tb_if.busy, 1'b0);

        // Four back-to-back records into a depth-2 FIFO: the fourth is dropped.
        for (int i = 0; i < 4; i++) begin
            tb_if.trValid = 1'b1;
            tb_if.trPc    = 32'(i * 4);
            tb_if.trInstr = 32'h1000_0000 + 32'(i);
            @(negedge clk);
        end
        tb_if.trValid = 1'b0;
        check("burst_overflow", tb_if.overflow, 1'b1);
        check("burst_dropCnt", tb_if.dropCnt, 8'd1);
        wait_idle(4 * (FRAME + 1), n);
        check("three_frames_cycles", n, 1080);

        // Trace disabled: strobes are ignored.
        tb_if.trEn = 1'b0;
        for (int i = 0; i < 20; i++) strobe(32'h2000 + 32'(i), 32'hFFFF_FFFF);
        check("disabled_busy", tb_if.busy, 1'b0);
        check("disabled_txd", tb_if.txd, 1'b1);
        check("disabled_dropCnt", tb_if.dropCnt, 8'd1);
        tb_if.trEn = 1'b1;

        // Reset during byte 3 aborts the frame; the next frame is complete.
        strobe(32'hCAFE_0000, 32'h1234_5678);
        repeat (126) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_txd", tb_if.txd, 1'b1);
        check("abort_busy", tb_if.busy, 1'b0);
        check("abort_dropCnt", tb_if.dropCnt, 8'd0);
        strobe(32'h0000_0100, 32'hDEAD_BEEF);
        capture_frame();
        fr = {8'hA5, 32'h0000_0100, 32'hDEAD_BEEF};
        for (int k = 0; k < 9; k++) check($sformatf("frame_after_abort_byte%0d", k), cap_bytes[k], fr[71 - 8*k -: 8]);
        wait_idle(10, n);

        // 300 pushes against a stalled serialiser saturate dropCnt.
        tb_if.trValid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tb_if.trPc    = 32'(i * 4);
            tb_if.trInstr = 32'(i);
            @(negedge clk);
        end
        tb_if.trValid = 1'b0;
        check("saturated_dropCnt", tb_if.dropCnt, 8'd255);
        check("saturated_overflow", tb_if.overflow, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Fill the FIFO, then push exactly on the edge that pops it.
        for (int i = 0; i < 3; i++) strobe(32'h4000 + 32'(i * 4), 32'h5000 + 32'(i));
        n = 0;
        while (m_pos != FRAME - 1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("pop_edge_found", n < 2 * FRAME, 1'b1);
        @(negedge clk);
        strobe(32'h4444_4444, 32'h5555_5555);
        check("push_on_pop_dropCnt", tb_if.dropCnt, 8'd0);
        check("push_on_pop_overflow", tb_if.overflow, 1'b0);
        wait_idle(4 * (FRAME + 1), n);

        // Randomized traffic with occasional resets.
        for (int seg = 0; seg < 8; seg++) begin
            thr = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 6 : 60);
            for (int i = 0; i < 1000; i++) begin
                rst           = ($urandom_range(0, 1499) == 0);
                tb_if.trEn    = ($urandom_range(0, 9) != 0);
                tb_if.trValid = ($urandom_range(0, 99) < thr);
                tb_if.trPc    = $urandom;
                tb_if.trInstr = $urandom;
                @(negedge clk);
            end
        end
        rst           = 1'b0;
        tb_if.trValid = 1'b0;
        wait_idle((DEPTH + 1) * (FRAME + 1) + 10, n);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
